// File: rtl/controle_varredura_servo_pkg.sv
// Shared definitions for the servo sweep controller: state encodings,
// position codes, 50 MHz timing defaults and the ping-pong step rule.
package controle_varredura_servo_pkg;

    typedef enum logic [2:0] {
        INICIAL = 3'b000,
        ACOMODA = 3'b001,
        MEDE    = 3'b010,
        AGUARDA = 3'b011,
        PROXIMA = 3'b100
    } estado_t;

    localparam logic [1:0] POS_OFF = 2'b00;
    localparam logic [1:0] POS_MIN = 2'b01;
    localparam logic [1:0] POS_MID = 2'b10;
    localparam logic [1:0] POS_MAX = 2'b11;

    // 0.5 s settling and 1 s acknowledge timeout at 50 MHz
    localparam int unsigned T_ACOMODA_PADRAO = 32'd25_000_000;
    localparam int unsigned T_TIMEOUT_PADRAO = 32'd50_000_000;

    typedef struct packed {
        logic [1:0] posicao;
        logic       sentido;
    } passo_t;

    // Back-and-forth step: reverse at the end stops, landing on the middle position.
    function automatic passo_t passo_vaivem(input logic [1:0] posicao,
                                            input logic       sentido);
        passo_t resultado;
        resultado.posicao = posicao;
        resultado.sentido = sentido;
        if (!sentido) begin
            if (posicao == POS_MAX) begin
                resultado.sentido = 1'b1;
                resultado.posicao = POS_MID;
            end else begin
                resultado.posicao = posicao + 2'd1;
            end
        end else begin
            if (posicao == POS_MIN) begin
                resultado.sentido = 1'b0;
                resultado.posicao = POS_MID;
            end else begin
                resultado.posicao = posicao - 2'd1;
            end
        end
        return resultado;
    endfunction

endpackage

// File: rtl/controle_varredura_servo_contador_tempo.sv
// 32-bit cycle timer: cleared by zera, advanced by conta, fim flags count = M-1.
module contador_tempo #(
    parameter int unsigned M = 32'd4
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [31:0] valor;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + 32'd1;
        end
    end

    assign fim = (valor == 32'(M - 32'd1));

endmodule

// File: rtl/controle_varredura_servo.sv
// Servo sweep controller: steps posicao 01-10-11-10-01..., settles, requests a
// measurement, then waits for medida_ok or a timeout before moving on.
module controle_varredura_servo
    import controle_varredura_servo_pkg::*;
#(
    parameter int unsigned T_ACOMODA = T_ACOMODA_PADRAO,
    parameter int unsigned T_TIMEOUT = T_TIMEOUT_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       medida_ok,
    output logic [1:0] posicao,
    output logic       pedir_medida,
    output logic       ativo,
    output logic       sentido,
    output logic       erro,
    output logic [2:0] db_estado
);

    estado_t    estado;
    estado_t    estado_prox;
    logic [1:0] posicao_prox;
    logic       sentido_prox;
    logic       erro_prox;
    logic       fim_acomoda;
    logic       fim_timeout;
    logic       em_acomoda;
    logic       em_aguarda;
    passo_t     passo;

    assign em_acomoda = (estado == ACOMODA);
    assign em_aguarda = (estado == AGUARDA);

    // Each timer is held at zero outside its own state, so it starts from 0
    // on every entry and ACOMODA lasts exactly T_ACOMODA cycles.
    contador_tempo #(.M(T_ACOMODA)) u_tempo_acomoda (
        .clock (clock),
        .reset (reset),
        .zera  (!em_acomoda),
        .conta (em_acomoda),
        .fim   (fim_acomoda)
    );

    contador_tempo #(.M(T_TIMEOUT)) u_tempo_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (!em_aguarda),
        .conta (em_aguarda),
        .fim   (fim_timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado  <= INICIAL;
            posicao <= POS_OFF;
            sentido <= 1'b0;
            erro    <= 1'b0;
        end else begin
            estado  <= estado_prox;
            posicao <= posicao_prox;
            sentido <= sentido_prox;
            erro    <= erro_prox;
        end
    end

    assign passo = passo_vaivem(posicao, sentido);

    // NOTE: every variable gets a default before the case so no path
    // leaves one unassigned, which would infer a latch.
    always_comb begin
        estado_prox  = estado;
        posicao_prox = posicao;
        sentido_prox = sentido;
        erro_prox    = erro;
        unique case (estado)
            INICIAL: begin
                posicao_prox = POS_OFF;
                if (ligar) begin
                    posicao_prox = POS_MIN;
                    sentido_prox = 1'b0;
                    erro_prox    = 1'b0;
                    estado_prox  = ACOMODA;
                end
            end
            ACOMODA: begin
                if (fim_acomoda) begin
                    estado_prox = MEDE;
                end
            end
            MEDE: begin
                estado_prox = AGUARDA;
            end
            AGUARDA: begin
                // An acknowledge arriving on the timeout cycle still counts as success.
                if (medida_ok) begin
                    estado_prox = PROXIMA;
                end else if (fim_timeout) begin
                    erro_prox   = 1'b1;
                    estado_prox = PROXIMA;
                end
            end
            PROXIMA: begin
                if (!ligar) begin
                    posicao_prox = POS_OFF;
                    sentido_prox = 1'b0;
                    estado_prox  = INICIAL;
                end else begin
                    posicao_prox = passo.posicao;
                    sentido_prox = passo.sentido;
                    estado_prox  = ACOMODA;
                end
            end
            default: begin
                posicao_prox = POS_OFF;
                sentido_prox = 1'b0;
                estado_prox  = INICIAL;
            end
        endcase
    end

    assign pedir_medida = (estado == MEDE);
    assign ativo        = (estado != INICIAL);
    assign db_estado    = estado;

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Randomized self-checking bench for controle_varredura_servo against a
// transaction-level model of the sweep (triangle-wave positions, sticky error).
module tb_controle_varredura_servo;

    localparam int T_AC = 4;
    localparam int T_TO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar;
    logic       medida_ok;
    logic [1:0] posicao;
    logic       pedir_medida;
    logic       ativo;
    logic       sentido;
    logic       erro;
    logic [2:0] db_estado;

    int total = 0;
    int bad   = 0;
    int passo = 0;
    int erro_exp = 0;

    controle_varredura_servo #(
        .T_ACOMODA (T_AC),
        .T_TIMEOUT (T_TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .medida_ok    (medida_ok),
        .posicao      (posicao),
        .pedir_medida (pedir_medida),
        .ativo        (ativo),
        .sentido      (sentido),
        .erro         (erro),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: obtido=timeout esperado=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic verificar(input string tag, input int obtido, input int esperado);
        total++;
        if (obtido !== esperado) begin
            bad++;
            $display("FAIL %s: obtido=%0d esperado=%0d (t=%0t)", tag, obtido, esperado, $time);
        end
    endtask

    // Position after n sweep steps: triangle wave 1,2,3,2,1,2,3,...
    function automatic int pos_de(input int n);
        case (n % 4)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            default: return 2;
        endcase
    endfunction

    // Direction flag reports whether the most recent step went downwards.
    function automatic int sentido_de(input int n);
        return (n > 0 && pos_de(n) < pos_de(n - 1)) ? 1 : 0;
    endfunction

    task automatic verificar_repouso(input string tag);
        verificar({tag, "_posicao"}, posicao, 0);
        verificar({tag, "_ativo"}, ativo, 0);
        verificar({tag, "_pedir"}, pedir_medida, 0);
        verificar({tag, "_sentido"}, sentido, 0);
        verificar({tag, "_estado"}, db_estado, 0);
        verificar({tag, "_erro"}, erro, erro_exp);
    endtask

    // Precondition: DUT idle. Returns at the negedge where the first position is visible.
    task automatic iniciar();
        ligar = 1'b1;
        @(negedge clock);
        passo    = 0;
        erro_exp = 0;
        verificar("inicio_posicao", posicao, 1);
        verificar("inicio_sentido", sentido, 0);
        verificar("inicio_erro", erro, 0);
        verificar("inicio_ativo", ativo, 1);
        verificar("inicio_estado", db_estado, 1);
    endtask

    // One position: a = AGUARDA cycle carrying medida_ok (a > T_TO means never),
    // esp_ac = ACOMODA cycle with a stray pulse (-1 none), esp_mede = stray pulse in MEDE.
    task automatic executar_posicao(input int a, input int esp_ac, input bit esp_mede,
                                    input bit manter);
        int n = 0;
        bit visto = 1'b0;
        bit estourou;
        int fim_k;
        ligar = manter;
        for (int k = 0; k < T_AC + 2 && !visto; k++) begin
            medida_ok = (k == esp_ac);
            @(negedge clock);
            n++;
            if (pedir_medida === 1'b1) visto = 1'b1;
        end
        verificar("atraso_pedido", visto ? n : -1, T_AC);
        verificar("posicao_na_medida", posicao, pos_de(passo));
        medida_ok = esp_mede;
        estourou = (a > T_TO);
        fim_k = estourou ? T_TO : a;
        for (int k = 1; k <= fim_k; k++) begin
            @(negedge clock);
            if (k == 1) verificar("largura_pedido", pedir_medida, 0);
            verificar("em_aguarda", db_estado, 3);
            medida_ok = (k == a);
        end
        @(negedge clock);
        medida_ok = 1'b0;
        if (estourou) erro_exp = 1;
        verificar("em_proxima", db_estado, 4);
        verificar("erro_proxima", erro, erro_exp);
        verificar("posicao_proxima", posicao, pos_de(passo));
        @(negedge clock);
        if (manter) begin
            passo++;
            verificar("nova_posicao", posicao, pos_de(passo));
            verificar("novo_sentido", sentido, sentido_de(passo));
            verificar("novo_ativo", ativo, 1);
            verificar("novo_estado", db_estado, 1);
            verificar("novo_erro", erro, erro_exp);
        end else begin
            verificar_repouso("desligado");
        end
    endtask

    // Precondition: at the start of a position with ligar=1.
    task automatic reset_no_aguarda();
        bit visto = 1'b0;
        for (int k = 0; k < T_AC + 2 && !visto; k++) begin
            @(negedge clock);
            if (pedir_medida === 1'b1) visto = 1'b1;
        end
        verificar("reset_pedido_visto", visto, 1);
        repeat (2) @(negedge clock);
        #2;
        reset = 1'b1;
        ligar = 1'b0;
        erro_exp = 0;
        #1;
        verificar_repouso("reset_assincrono");
        @(negedge clock);
        verificar_repouso("reset_mantido");
        reset = 1'b0;
        @(negedge clock);
        verificar_repouso("apos_reset");
        iniciar();
    endtask

    initial begin
        reset     = 1'b1;
        ligar     = 1'b0;
        medida_ok = 1'b0;
        repeat (2) @(negedge clock);
        verificar_repouso("reset");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        verificar_repouso("ocioso");

        // Full sweep 01,10,11,10,01,10 with ack two cycles after each request,
        // then ligar dropped during the last 10 position.
        iniciar();
        for (int i = 0; i < 5; i++) executar_posicao(2, -1, 1'b0, 1'b1);
        executar_posicao(2, -1, 1'b0, 1'b0);

        // Timeout at 01, sticky error across positions and into idle.
        iniciar();
        executar_posicao(1000, -1, 1'b0, 1'b1);
        executar_posicao(1, -1, 1'b0, 1'b1);
        executar_posicao(3, -1, 1'b0, 1'b0);

        // Ack on the timeout cycle, then stray pulses in ACOMODA and MEDE.
        iniciar();
        executar_posicao(T_TO, -1, 1'b0, 1'b1);
        executar_posicao(3, 1, 1'b1, 1'b1);
        executar_posicao(1, T_AC - 1, 1'b1, 1'b1);
        executar_posicao(T_TO + 1, 0, 1'b1, 1'b1);

        reset_no_aguarda();

        for (int i = 0; i < 60; i++) begin
            int  a;
            int  esp;
            bit  esp_mede;
            bit  manter;
            a = int'($urandom_range(1, T_TO + 2));
            if ($urandom_range(0, 2) == 0) esp = int'($urandom_range(0, T_AC - 1));
            else esp = -1;
            esp_mede = ($urandom_range(0, 3) == 0);
            manter   = ($urandom_range(0, 5) != 0);
            executar_posicao(a, esp, esp_mede, manter);
            if (!manter) begin
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clock);
                    verificar("ocioso_aleatorio", db_estado, 0);
                end
                iniciar();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_varredura_servo.md
Name: controle_varredura_servo

Overview:
- Sweep controller that sits directly upstream of the servo PWM generator and drives its 2-bit width select (posicao).
- Steps the servo through the three active positions 01→10→11→10→01… in a back-and-forth sweep.
- At each position it waits a settling time, pulses a measurement request to the sensor block, then waits for its acknowledge or a timeout before moving on.
- posicao=00 means servo off (zero width) and is driven whenever the sweep is idle.

Parameters:
- T_ACOMODA, 25000000, settling cycles per position (0.5 s @ 50 MHz); must be ≥1.
- T_TIMEOUT, 50000000, maximum cycles waiting for medida_ok (1 s @ 50 MHz); must be ≥1.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- ligar  in  1  level; 1 = sweep enabled.
- medida_ok  in  1  one-cycle acknowledge from the measurement block.
- posicao  out  2  width select to the PWM generator.
- pedir_medida  out  1  one-cycle measurement request.
- ativo  out  1  1 whenever state ≠ INICIAL.
- sentido  out  1  0 = increasing position, 1 = decreasing.
- erro  out  1  sticky flag: a measurement timed out.
- db_estado  out  3  current state encoding, for debug.

Behaviour:
- Reset is asynchronous, active-high; clock is clock. All outputs are registered or Moore-decoded from registered state.
- Reset values: posicao=00, pedir_medida=0, ativo=0, sentido=0, erro=0, db_estado=000, timer=0, state=INICIAL. Reset asserted mid-sweep returns to this immediately.
- States and encodings: INICIAL=000, ACOMODA=001, MEDE=010, AGUARDA=011, PROXIMA=100. Unused codes go to INICIAL.
- INICIAL: posicao=00.
  - If ligar=1: posicao←01, sentido←0, erro←0, timer←0, go to ACOMODA.
- ACOMODA: timer counts every cycle.
  - When timer=T_ACOMODA−1: timer←0, go to MEDE.
  - ACOMODA therefore lasts exactly T_ACOMODA cycles.
- MEDE: one cycle; pedir_medida=1 (decoded from state). timer←0, go to AGUARDA.
  - pedir_medida rises exactly T_ACOMODA cycles after posicao changes.
- AGUARDA: timer counts every cycle.
  - If medida_ok=1: go to PROXIMA.
  - Else if timer=T_TIMEOUT−1: erro←1, go to PROXIMA.
  - medida_ok and timeout in the same cycle: medida_ok wins, erro is unchanged.
- PROXIMA: one cycle.
  - If ligar=0: posicao←00, sentido←0, go to INICIAL.
  - Otherwise apply the ping-pong step, timer←0, go to ACOMODA:
    - sentido=0 and posicao<11: posicao+1.
    - sentido=0 and posicao=11: sentido←1, posicao←10.
    - sentido=1 and posicao>01: posicao−1.
    - sentido=1 and posicao=01: sentido←0, posicao←10.
  - posicao never takes the value 00 while ativo=1.
- ligar is sampled only in INICIAL and PROXIMA. Dropping it mid-position lets the current measurement complete or time out first.
- medida_ok outside AGUARDA is ignored.
- Timer is 32-bit unsigned and cleared on every state entry that counts. No wrap-around is reachable.
- erro stays 1 across later positions. It clears only on reset or on leaving INICIAL.

Decomposition:
- Shared package holds:
  - state encodings (INICIAL…PROXIMA, 3-bit);
  - position constants POS_OFF=00, POS_MIN=01, POS_MID=10, POS_MAX=11;
  - default timing constants for 50 MHz.
- One sub-module, contador_tempo: 32-bit timer with inputs zera and conta, parameter M, output fim (count=M−1).
  - Instanced twice (M=T_ACOMODA, M=T_TIMEOUT) or once with a muxed limit. The FSM remains in the top module.

Test Plan (T_ACOMODA=4, T_TIMEOUT=8):
1. Reset, then ligar=1 held, medida_ok returned 2 cycles after each pedir_medida → posicao sequence 01,10,11,10,01,10; sentido toggles at 11 and 01; each pedir_medida pulse is 1 cycle wide and occurs 4 cycles after its posicao change; erro=0.
2. ligar=1, medida_ok never asserted → AGUARDA lasts exactly 8 cycles; erro=1 from the following cycle and stays 1; posicao advances 01→10.
3. medida_ok asserted in the same cycle the timer reaches 7 → erro remains 0; normal advance.
4. ligar dropped to 0 during ACOMODA at posicao=10 → pedir_medida still issued; after medida_ok, state goes PROXIMA→INICIAL; posicao=00, ativo=0, db_estado=000.
5. medida_ok pulses during ACOMODA and MEDE → ignored: no early advance, and AGUARDA still waits for a fresh medida_ok.
6. Asynchronous reset asserted mid-AGUARDA, off a clock edge → all outputs immediately take their reset values; sweep restarts at 01 after reset is released with ligar=1.
